md_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS CPU, placed in EX beside the combinational ALU. It latches operands on a one-cycle start pulse, holds `busy` for a configurable latency, then commits the result to HI/LO. Hazard logic stalls any mult/div/mfhi/mflo/mthi/mtlo in ID while `start` or `busy` is high. Latencies and datapath width are parameters.

---
 rtl/md_if.sv | 15 +
 rtl/md_unit.sv | 138 +++++++++++++
 tb/tb_md_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/md_if.sv
// Launch/operand bundle and HI/LO result bundle between the EX stage and md_unit.
interface md_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [3:0]       MDOp;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, MDOp, srcA, srcB, input busy, hi, lo);
  modport slave  (input start, MDOp, srcA, srcB, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed at launch and committed after the latency.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by defining MD_MADD_EN.
//
// state | meaning
// IDLE  | no op in flight; accepts launch, MTHI, MTLO
// RUN   | counting down latency; result pending, commit when counter hits 1
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  md_if.slave  md
);
  localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {C_SET, C_SKIP, C_ADD, C_SUB} commit_t;

  state_t             state;
  commit_t            pend_kind;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] pend;
  logic               busy_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [2*WIDTH-1:0] ext_as, ext_bs, ext_au, ext_bu, prod_s, prod_u;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   bs_safe, bu_safe, q_u, r_u;
  logic signed [WIDTH-1:0] q_s, r_s;

  assign ext_as = {{WIDTH{md.srcA[WIDTH-1]}}, md.srcA};
  assign ext_bs = {{WIDTH{md.srcB[WIDTH-1]}}, md.srcB};
  assign ext_au = {{WIDTH{1'b0}}, md.srcA};
  assign ext_bu = {{WIDTH{1'b0}}, md.srcB};
  assign prod_s = ext_as * ext_bs;
  assign prod_u = ext_au * ext_bu;

  // Most-negative / -1 is steered to a divide by 1, which yields the wrapped quotient and zero remainder.
  assign div_zero = (md.srcB == '0);
  assign div_ovf  = (md.srcA == {1'b1, {(WIDTH-1){1'b0}}}) && (md.srcB == '1);
  assign bs_safe  = (div_zero || div_ovf) ? WIDTH'(1) : md.srcB;
  assign bu_safe  = div_zero ? WIDTH'(1) : md.srcB;
  assign q_s      = $signed(md.srcA) / $signed(bs_safe);
  assign r_s      = $signed(md.srcA) % $signed(bs_safe);
  assign q_u      = md.srcA / bu_safe;
  assign r_u      = md.srcA % bu_safe;

  logic               launch;
  logic [CW-1:0]      lat_sel;
  commit_t            kind_sel;
  logic [2*WIDTH-1:0] res_sel;

  always_comb begin
    launch   = 1'b0;
    lat_sel  = CW'(MULT_LAT);
    kind_sel = C_SET;
    res_sel  = '0;
    if (md.start) begin
      case (md.MDOp)
        4'd1: begin launch = 1'b1; res_sel = prod_s; end
        4'd2: begin launch = 1'b1; res_sel = prod_u; end
        4'd3: begin
          launch   = 1'b1;
          lat_sel  = CW'(DIV_LAT);
          res_sel  = {r_s, q_s};
          kind_sel = div_zero ? C_SKIP : C_SET;
        end
        4'd4: begin
          launch   = 1'b1;
          lat_sel  = CW'(DIV_LAT);
          res_sel  = {r_u, q_u};
          kind_sel = div_zero ? C_SKIP : C_SET;
        end
`ifdef MD_MADD_EN
        4'd7:  begin launch = 1'b1; res_sel = prod_s; kind_sel = C_ADD; end
        4'd8:  begin launch = 1'b1; res_sel = prod_u; kind_sel = C_ADD; end
        4'd9:  begin launch = 1'b1; res_sel = prod_s; kind_sel = C_SUB; end
        4'd10: begin launch = 1'b1; res_sel = prod_u; kind_sel = C_SUB; end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      cnt       <= '0;
      pend      <= '0;
      pend_kind <= C_SET;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state     <= RUN;
            busy_q    <= 1'b1;
            cnt       <= lat_sel;
            pend      <= res_sel;
            pend_kind <= kind_sel;
          end else if (!md.start && md.MDOp == 4'd5) begin
            hi_q <= md.srcA;
          end else if (!md.start && md.MDOp == 4'd6) begin
            lo_q <= md.srcA;
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            case (pend_kind)
              C_SET: {hi_q, lo_q} <= pend;
`ifdef MD_MADD_EN
              C_ADD: {hi_q, lo_q} <= {hi_q, lo_q} + pend;
              C_SUB: {hi_q, lo_q} <= {hi_q, lo_q} - pend;
`endif
              default: ;
            endcase
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a 64-bit arithmetic reference model checked every cycle, plus directed literal checks.
module tb_md_unit;
  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  md_if #(.WIDTH(W)) mdi ();
  md_unit #(.WIDTH(W), .MULT_LAT(ML), .DIV_LAT(DL)) dut (.clk(clk), .reset(reset), .md(mdi));

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: ops are done with 64-bit integers, latency as a remaining-cycle count.
  int          m_cnt = 0;
  int          m_kind = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin : model_p
    logic [31:0] a, b;
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    a = mdi.srcA;
    b = mdi.srcB;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (!reset) begin
      m_cnt = 0; m_hi = '0; m_lo = '0; m_pend = '0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        case (m_kind)
          0: {m_hi, m_lo} = m_pend;
          2: {m_hi, m_lo} = {m_hi, m_lo} + m_pend;
          3: {m_hi, m_lo} = {m_hi, m_lo} - m_pend;
          default: ;
        endcase
      end
    end else if (mdi.start) begin
      case (mdi.MDOp)
        4'd1: begin m_pend = sa * sb; m_kind = 0; m_cnt = ML; end
        4'd2: begin m_pend = ua * ub; m_kind = 0; m_cnt = ML; end
        4'd3: begin
          m_cnt = DL;
          if (b == 0) m_kind = 1;
          else begin
            q = sa / sb; r = sa % sb;
            m_pend = {r[31:0], q[31:0]}; m_kind = 0;
          end
        end
        4'd4: begin
          m_cnt = DL;
          if (b == 0) m_kind = 1;
          else begin
            uq = ua / ub; ur = ua % ub;
            m_pend = {ur[31:0], uq[31:0]}; m_kind = 0;
          end
        end
`ifdef MD_MADD_EN
        4'd7:  begin m_pend = sa * sb; m_kind = 2; m_cnt = ML; end
        4'd8:  begin m_pend = ua * ub; m_kind = 2; m_cnt = ML; end
        4'd9:  begin m_pend = sa * sb; m_kind = 3; m_cnt = ML; end
        4'd10: begin m_pend = ua * ub; m_kind = 3; m_cnt = ML; end
`endif
        default: ;
      endcase
    end else if (mdi.MDOp == 4'd5) begin
      m_hi = a;
    end else if (mdi.MDOp == 4'd6) begin
      m_lo = a;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", {63'b0, mdi.busy}, {63'b0, (m_cnt > 0)});
      chk("model_hi", {32'b0, mdi.hi}, {32'b0, m_hi});
      chk("model_lo", {32'b0, mdi.lo}, {32'b0, m_lo});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic st);
    mdi.start = st;
    mdi.MDOp  = op;
    mdi.srcA  = a;
    mdi.srcB  = b;
    tick();
    mdi.start = 1'b0;
    mdi.MDOp  = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (mdi.busy && n < 60) begin
      n++;
      tick();
    end
    if (n >= 60) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=%0d cycles required=<60", n);
    end
  endtask

  initial begin
    int n;
    mdi.start = 1'b0; mdi.MDOp = 4'd0; mdi.srcA = '0; mdi.srcB = '0;
    reset = 1'b0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    chk("reset_busy", {63'b0, mdi.busy}, 64'd0);
    chk("reset_hilo", {mdi.hi, mdi.lo}, 64'd0);
    reset = 1'b1;
    tick();

    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
    wait_idle(n);
    chk("mult_busy_len", n, ML);
    chk("mult_neg", {mdi.hi, mdi.lo}, 64'hFFFFFFFF_FFFFFFFA);

    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_idle(n);
    chk("multu_max", {mdi.hi, mdi.lo}, 64'hFFFFFFFE_00000001);

    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_idle(n);
    chk("div_busy_len", n, DL);
    chk("div_neg", {mdi.hi, mdi.lo}, 64'hFFFFFFFF_FFFFFFFD);

    issue(4'd5, 32'h11, 32'd0, 1'b0);
    issue(4'd6, 32'h22, 32'd0, 1'b0);
    issue(4'd4, 32'd7, 32'd0, 1'b1);
    wait_idle(n);
    chk("divu_zero_len", n, DL);
    chk("divu_zero_hold", {mdi.hi, mdi.lo}, 64'h00000011_00000022);

    issue(4'd6, 32'h1234, 32'd0, 1'b0);
    chk("mtlo_busy", {63'b0, mdi.busy}, 64'd0);
    chk("mtlo_val", {32'b0, mdi.lo}, 64'h1234);

    issue(4'd3, 32'd100, 32'd7, 1'b1);
    tick(); tick();
    mdi.MDOp = 4'd5; mdi.srcA = 32'hDEAD_BEEF;
    tick();
    mdi.MDOp = 4'd0;
    wait_idle(n);
    chk("div_mthi_len", n, 7);
    chk("div_mthi_ignored", {mdi.hi, mdi.lo}, {32'd2, 32'd14});

    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_idle(n);
    chk("div_ovf", {mdi.hi, mdi.lo}, 64'h00000000_80000000);

    issue(4'd0, 32'd1, 32'd1, 1'b1);
    chk("noop0_busy", {63'b0, mdi.busy}, 64'd0);
    issue(4'd11, 32'd1, 32'd1, 1'b1);
    chk("noop11_busy", {63'b0, mdi.busy}, 64'd0);
    issue(4'd5, 32'hABCD, 32'd0, 1'b1);
    chk("mthi_with_start", {32'b0, mdi.hi}, 64'd0);

    issue(4'd1, 32'd5, 32'd5, 1'b1);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("midrun_reset_busy", {63'b0, mdi.busy}, 64'd0);
    chk("midrun_reset_hilo", {mdi.hi, mdi.lo}, 64'd0);
    reset = 1'b1;
    issue(4'd1, 32'd6, 32'd7, 1'b1);
    wait_idle(n);
    chk("mult_after_reset", {mdi.hi, mdi.lo}, 64'd42);

    issue(4'd5, 32'd0, 32'd0, 1'b0);
    issue(4'd6, 32'd10, 32'd0, 1'b0);
`ifdef MD_MADD_EN
    issue(4'd7, 32'd3, 32'd4, 1'b1);
    wait_idle(n);
    chk("madd_len", n, ML);
    chk("madd_val", {mdi.hi, mdi.lo}, 64'd22);
    issue(4'd10, 32'd1, 32'd23, 1'b1);
    wait_idle(n);
    chk("msubu_val", {mdi.hi, mdi.lo}, 64'hFFFFFFFF_FFFFFFFF);
`else
    issue(4'd7, 32'd3, 32'd4, 1'b1);
    chk("madd_off_busy", {63'b0, mdi.busy}, 64'd0);
    tick(); tick();
    chk("madd_off_hilo", {mdi.hi, mdi.lo}, 64'd10);
`endif

    tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
